peak_event_pio: RTL

Avalon-MM slave input port that samples external peak-detector status lines, records edges in a sticky capture register, and raises a maskable interrupt to the Nios II processor. It is the processor-side receiver for the peak path: the existing output PIO drives `peak_reset` out to the detector, and this block brings `peak_event` status back in. It sits in the QSYS system on the same bus and clock as the other PIOs.

---
 rtl/peak_event_pio_if.sv | 25 ++
 rtl/peak_event_pio.sv | 85 ++++++++
 2 files changed

// File: rtl/peak_event_pio_if.sv
// peak_event_pio_if: Avalon-MM slave bus bundle for the peak event PIO.
// The bus master drives the request fields, and the slave returns readdata.
interface peak_event_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/peak_event_pio.sv
// peak_event_pio: input PIO that samples peak-detector status lines into a
// sticky edge-capture register and raises a maskable level interrupt.
module peak_event_pio #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    peak_event_pio_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync3;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] cap_next;
    logic [31:0]      rd_value;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign rd_en     = bus.chipselect & bus.write_n;
    assign unused_wd = ^bus.writedata;

    // Edge detect between the synchronised value and its previous sample.
    always_comb begin
        edges = '0;
        if (EDGE_TYPE == 0) begin
            edges = sync2 & ~sync3;
        end else if (EDGE_TYPE == 1) begin
            edges = ~sync2 & sync3;
        end else begin
            edges = sync2 ^ sync3;
        end
    end

    // Write-1-to-clear first, then new edges set, so an edge beats a clear.
    always_comb begin
        cap_next = edgecapture;
        if (wr_en && bus.address == 2'd3) begin
            cap_next = edgecapture & ~bus.writedata[WIDTH-1:0];
        end
        cap_next = cap_next | edges;
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_value = '0;
        case (bus.address)
            2'd0:    rd_value[WIDTH-1:0] = sync2;
            2'd2:    rd_value[WIDTH-1:0] = irqmask;
            2'd3:    rd_value[WIDTH-1:0] = edgecapture;
            default: rd_value = '0;
        endcase
    end

    // Synchroniser, registers and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            bus.readdata <= '0;
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            sync3       <= sync2;
            edgecapture <= cap_next;
            if (wr_en && bus.address == 2'd2) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            bus.readdata <= rd_en ? rd_value : 32'd0;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule
